abs_diff_serial: RTL
====================

ABS_DIFF_SERIAL -- requirements
Module: abs_diff_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal values are even and 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: unsigned minuend; captured on the edge that accepts start.
REQ-006 SHALL have port b, input, WIDTH bits: unsigned subtrahend; captured on the same edge as a.
REQ-007 SHALL have port busy, output, 1 bit: high in SUB and NEG.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-009 SHALL have port result, output, WIDTH bits: |a - b|, registered.
REQ-010 SHALL have port a_lt_b, output, 1 bit: high when a < b; present only with ABS_DIFF_SIGN_EN.

Function
REQ-011 SHALL compute |a - b| serially, 2 bits per cycle, LSB slice first, through one 2-bit adder slice plus a 1-bit carry register.
REQ-012 SHALL implement the states IDLE, SUB, NEG and DONE.
REQ-013 SHALL, in IDLE with start=1: capture a and b, set carry=1, set slice index=0, and go to SUB; start=0 keeps IDLE.
REQ-014 SHALL, in SUB, add slice i of a to slice i of ~b plus carry each cycle, write the sum into slice i of the working register, update carry, and increment i.
REQ-015 SHALL, at the end of the last SUB slice, go to DONE if the final carry is 1 (a >= b), else go to NEG with carry=1 and i=0.
REQ-016 SHALL, in NEG, form ~D + carry slice by slice over the working register (two's-complement negate), taking WIDTH/2 cycles, then go to DONE.
REQ-017 SHALL, in DONE, load result from the working register, pulse done for exactly one cycle, and return to IDLE.
REQ-018 SHALL assert done WIDTH/2 + 1 edges after the accepting edge when a >= b, and WIDTH + 1 edges after it when a < b.
REQ-019 SHALL hold result stable from DONE until the next DONE.
REQ-020 SHALL ignore start while busy or in DONE, with no queuing.
REQ-021 SHALL handle a = b by going SUB -> DONE (carry 1) with result 0.
REQ-022 SHALL keep the slice index within 0..WIDTH/2-1 and wrap it to 0 on every phase change.
REQ-023 SHALL give start=1 held continuously one accepted operation per IDLE visit, so back-to-back operations have a 1-cycle IDLE gap.

Reset
REQ-024 SHALL, on rst=1, immediately force state=IDLE, busy=0, done=0, result=0, carry=0, index=0, working register=0 and a_lt_b=0.
REQ-025 SHALL, on reset during SUB or NEG, abort the operation with no done pulse and keep result=0.
REQ-026 SHALL, after rst deasserts, accept start no earlier than the first following clock edge.

Configuration
REQ-027 SHALL, when ABS_DIFF_SIGN_EN is defined, provide port a_lt_b, registered in DONE as the inverse of the final SUB carry and held until the next DONE.
REQ-028 SHALL, when ABS_DIFF_SIGN_EN is undefined, have no a_lt_b port and no sign register, with all other behaviour identical.

Structure
REQ-029 SHALL take the state encoding (IDLE/SUB/NEG/DONE enum) and the SLICE_W=2 constant from the shared package abs_diff_pkg.
REQ-030 SHALL instantiate exactly one sub-module, two_bit_adder_slice (2-bit A, 2-bit B, carry in; 2-bit sum, carry out; combinational), reused by both SUB and NEG.
REQ-031 SHALL feed the slice ~working-register slice and 2'b00 in NEG, with the muxing done in the parent.

Verification (WIDTH=8)
REQ-032 Bench SHALL cover: a=200, b=55 -> result=145, done 5 edges after accept, a_lt_b=0.
REQ-033 Bench SHALL cover: a=55, b=200 -> result=145, done 9 edges after accept, a_lt_b=1.
REQ-034 Bench SHALL cover: a=b=0x5A -> result=0, done 5 edges after accept, a_lt_b=0; and a=0, b=255 -> result=255 after 9 edges.
REQ-035 Bench SHALL cover: start pulsed again with a=1, b=0 during busy from a=10, b=3 -> single done, result=7, second request dropped.
REQ-036 Bench SHALL cover: rst asserted 2 cycles into NEG (a=3, b=9) -> outputs zero immediately, no done; then a=9, b=3 -> result=6.

Source files
------------

// File: rtl/abs_diff_pkg.sv
// Shared types and constants for the serial absolute-difference unit.
package abs_diff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } abs_state_e;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/two_bit_adder_slice.sv
// Combinational 2-bit adder slice with carry in/out, shared by subtract and negate phases.
module two_bit_adder_slice (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       cin_i,
  output logic [1:0] sum_o,
  output logic       cout_o
);

  logic [2:0] total;

  always_comb begin
    total  = {1'b0, a_i} + {1'b0, b_i} + {2'b00, cin_i};
    sum_o  = total[1:0];
    cout_o = total[2];
  end

endmodule

// File: rtl/abs_diff_serial.sv
// Serial |a - b| unit, 2 bits per cycle: subtract pass, then an optional negate pass.
// Defining ABS_DIFF_SIGN_EN adds the registered a_lt_b output.
module abs_diff_serial
  import abs_diff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef ABS_DIFF_SIGN_EN
  output logic [WIDTH-1:0] result,
  output logic             a_lt_b
`else
  output logic [WIDTH-1:0] result
`endif
);

  localparam int STEPS = WIDTH / SLICE_W;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  abs_state_e       state_q, state_d;
  logic [WIDTH-1:0] aOp_q, aOp_d, bOp_q, bOp_d;
  logic [WIDTH-1:0] work_q, work_d, result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
`ifdef ABS_DIFF_SIGN_EN
  logic             subCarry_q, subCarry_d;
  logic             aLtB_q, aLtB_d;
`endif

  logic [SLICE_W-1:0] addA, addB, addSum;
  logic               addCout;
  int                 sliceBase;

  // The parent selects the adder operands: a + ~b while subtracting, ~D + 0 while negating.
  always_comb begin
    sliceBase = int'(idx_q) * SLICE_W;
    addA      = '0;
    addB      = '0;
    case (state_q)
      SUB: begin
        addA = aOp_q[sliceBase +: SLICE_W];
        addB = ~bOp_q[sliceBase +: SLICE_W];
      end
      NEG: begin
        addA = ~work_q[sliceBase +: SLICE_W];
        addB = '0;
      end
      default: ;
    endcase
  end

  two_bit_adder_slice uSlice (
    .a_i   (addA),
    .b_i   (addB),
    .cin_i (carry_q),
    .sum_o (addSum),
    .cout_o(addCout)
  );

  always_comb begin
    state_d  = state_q;
    aOp_d    = aOp_q;
    bOp_d    = bOp_q;
    work_d   = work_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
`ifdef ABS_DIFF_SIGN_EN
    subCarry_d = subCarry_q;
    aLtB_d     = aLtB_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          aOp_d   = a;
          bOp_d   = b;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        work_d[sliceBase +: SLICE_W] = addSum;
        carry_d = addCout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef ABS_DIFF_SIGN_EN
          subCarry_d = addCout;
`endif
          // A final carry of 0 means a < b, so the difference must be negated.
          if (addCout) begin
            state_d = DONE;
          end else begin
            carry_d = 1'b1;
            state_d = NEG;
          end
        end
      end
      NEG: begin
        work_d[sliceBase +: SLICE_W] = addSum;
        carry_d = addCout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = work_q;
        done_d   = 1'b1;
`ifdef ABS_DIFF_SIGN_EN
        aLtB_d = ~subCarry_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      aOp_q    <= '0;
      bOp_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef ABS_DIFF_SIGN_EN
      subCarry_q <= 1'b0;
      aLtB_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      aOp_q    <= aOp_d;
      bOp_q    <= bOp_d;
      work_q   <= work_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
`ifdef ABS_DIFF_SIGN_EN
      subCarry_q <= subCarry_d;
      aLtB_q     <= aLtB_d;
`endif
    end
  end

  assign busy   = (state_q == SUB) || (state_q == NEG);
  assign done   = done_q;
  assign result = result_q;
`ifdef ABS_DIFF_SIGN_EN
  assign a_lt_b = aLtB_q;
`endif

endmodule
